// File: rtl/imem_loader_if.sv
// Loader bus: image-source handshake, byte-write port to the instruction store, and status.
interface imem_loader_if #(parameter int ADDR_W = 64);
  logic              Load_Start;
  logic [15:0]       Load_Len;
  logic              Load_Abort;
  logic [7:0]        Rx_Data;
  logic              Rx_Valid;
  logic              Rx_Ready;
  logic              Mem_Wr_En;
  logic [ADDR_W-1:0] Mem_Wr_Addr;
  logic [7:0]        Mem_Wr_Data;
  logic [31:0]       Instr_Word;
  logic              Word_Valid;
  logic [7:0]        Checksum;
  logic              Load_Busy;
  logic              Load_Done;
  logic              Load_Err;
  logic              Core_Hold;

  modport master (
    output Load_Start, Load_Len, Load_Abort, Rx_Data, Rx_Valid,
    input  Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data, Instr_Word, Word_Valid,
           Checksum, Load_Busy, Load_Done, Load_Err, Core_Hold
  );

  modport slave (
    input  Load_Start, Load_Len, Load_Abort, Rx_Data, Rx_Valid,
    output Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data, Instr_Word, Word_Valid,
           Checksum, Load_Busy, Load_Done, Load_Err, Core_Hold
  );
endinterface

// File: rtl/imem_loader.sv
// Streams an image byte-by-byte into the instruction store, rebuilds little-endian words,
// and holds the core in reset until the full image has been written.
module imem_loader #(
  parameter int                ADDR_W    = 64,
  parameter int                MEM_BYTES = 132,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic        clk,
  input logic        reset,
  imem_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  localparam logic [15:0] MAX_LEN = 16'(MEM_BYTES);

  state_e            state_q;
  logic [15:0]       idx_q, len_q;
  logic [7:0]        cks_q;
  logic              wr_en_q, wv_q, err_q, hold_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [31:0]       word_q;
  logic [2:0][7:0]   lane_q;

  logic len_ok, last_byte;
  assign len_ok    = (bus.Load_Len != 16'd0) && (bus.Load_Len[1:0] == 2'b00) &&
                     (bus.Load_Len <= MAX_LEN);
  assign last_byte = (idx_q == len_q - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      cks_q     <= '0;
      wr_en_q   <= 1'b0;
      wv_q      <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b1;
      wr_addr_q <= BASE_ADDR;
      wr_data_q <= '0;
      word_q    <= '0;
      lane_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          // The first DONE cycle carries the final write; release the core right after it.
          if (state_q == DONE) hold_q <= 1'b0;
          if (bus.Load_Start) begin
            if (len_ok) begin
              state_q <= LOAD;
              idx_q   <= '0;
              cks_q   <= '0;
              len_q   <= bus.Load_Len;
              hold_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.Load_Abort) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else if (bus.Rx_Valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= BASE_ADDR + ADDR_W'(idx_q);
            wr_data_q <= bus.Rx_Data;
            idx_q     <= idx_q + 16'd1;
            cks_q     <= cks_q + bus.Rx_Data;
            if (idx_q[1:0] == 2'd3) begin
              word_q <= {bus.Rx_Data, lane_q[2], lane_q[1], lane_q[0]};
              wv_q   <= 1'b1;
            end else begin
              lane_q[idx_q[1:0]] <= bus.Rx_Data;
            end
            if (last_byte) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Rx_Ready    = (state_q == LOAD);
  assign bus.Load_Busy   = (state_q == LOAD);
  assign bus.Load_Done   = (state_q == DONE);
  assign bus.Mem_Wr_En   = wr_en_q;
  assign bus.Mem_Wr_Addr = wr_addr_q;
  assign bus.Mem_Wr_Data = wr_data_q;
  assign bus.Instr_Word  = word_q;
  assign bus.Word_Valid  = wv_q;
  assign bus.Checksum    = cks_q;
  assign bus.Load_Err    = err_q;
  assign bus.Core_Hold   = hold_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader; expectations come from the image array and byte counts.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(64)) bus();
  imem_loader #(.ADDR_W(64), .MEM_BYTES(132), .BASE_ADDR(64'd0)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0, passed = 0, fails = 0;
  int wv_cnt, wr_cnt;
  logic [63:0] last_addr;
  logic [7:0]  img [0:131];
  int pat [6] = '{1, 0, 1, 1, 0, 1};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [7:0] img_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += img[i];
    return 8'(s);
  endfunction

  task automatic rand_img;
    for (int i = 0; i < 132; i++) img[i] = 8'($urandom);
  endtask

  // mode 0: random Rx_Valid, 1: back-to-back, 2: 1,0,1,1,0,1 pattern
  task automatic do_load(input int len, input int mode, input int abort_at);
    int k = 0, cyc = 0;
    logic v, ab;
    bus.Load_Start = 1'b1; bus.Load_Len = 16'(len);
    tick;
    bus.Load_Start = 1'b0;
    chk("start_busy", 64'(bus.Load_Busy), 64'd1);
    chk("start_ready", 64'(bus.Rx_Ready), 64'd1);
    chk("start_hold", 64'(bus.Core_Hold), 64'd1);
    chk("start_done", 64'(bus.Load_Done), 64'd0);
    chk("start_cks", 64'(bus.Checksum), 64'd0);
    while (k < len) begin
      if (cyc > 4 * len + 50) begin
        total++; fails++;
        $error("FAIL load_timeout: got %0d bytes expected %0d", k, len);
        return;
      end
      v  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'(pat[cyc % 6]) : 1'($urandom % 2);
      ab = v && (abort_at == k);
      bus.Rx_Valid = v; bus.Rx_Data = img[k]; bus.Load_Abort = ab;
      if (mode == 0 && cyc == 1) begin bus.Load_Start = 1'b1; bus.Load_Len = 16'd4; end
      tick; cyc++;
      bus.Rx_Valid = 1'b0; bus.Load_Abort = 1'b0; bus.Load_Start = 1'b0;
      if (ab) begin
        chk("abort_err", 64'(bus.Load_Err), 64'd1);
        chk("abort_wr", 64'(bus.Mem_Wr_En), 64'd0);
        chk("abort_busy", 64'(bus.Load_Busy), 64'd0);
        chk("abort_ready", 64'(bus.Rx_Ready), 64'd0);
        chk("abort_hold", 64'(bus.Core_Hold), 64'd1);
        chk("abort_done", 64'(bus.Load_Done), 64'd0);
        tick;
        chk("abort_err_pulse", 64'(bus.Load_Err), 64'd0);
        return;
      end
      if (v) begin
        chk("wr_en", 64'(bus.Mem_Wr_En), 64'd1);
        chk("wr_addr", bus.Mem_Wr_Addr, 64'(k));
        chk("wr_data", 64'(bus.Mem_Wr_Data), 64'(img[k]));
        wr_cnt++; last_addr = bus.Mem_Wr_Addr;
        if (k % 4 == 3) begin
          chk("word_valid", 64'(bus.Word_Valid), 64'd1);
          chk("instr_word", 64'(bus.Instr_Word), 64'({img[k], img[k-1], img[k-2], img[k-3]}));
          wv_cnt++;
        end else chk("word_valid_lo", 64'(bus.Word_Valid), 64'd0);
        k++;
      end else begin
        chk("wr_idle", 64'(bus.Mem_Wr_En), 64'd0);
        chk("wv_idle", 64'(bus.Word_Valid), 64'd0);
      end
    end
    chk("done", 64'(bus.Load_Done), 64'd1);
    chk("done_busy", 64'(bus.Load_Busy), 64'd0);
    chk("done_ready", 64'(bus.Rx_Ready), 64'd0);
    chk("done_hold_lastwr", 64'(bus.Core_Hold), 64'd1);
    chk("checksum", 64'(bus.Checksum), 64'(img_sum(len)));
    tick;
    chk("hold_released", 64'(bus.Core_Hold), 64'd0);
    chk("no_extra_wr", 64'(bus.Mem_Wr_En), 64'd0);
    chk("done_stays", 64'(bus.Load_Done), 64'd1);
  endtask

  task automatic bad_start(input int len, input logic exp_hold, input logic exp_done);
    bus.Load_Start = 1'b1; bus.Load_Len = 16'(len);
    tick;
    bus.Load_Start = 1'b0;
    chk("bad_err", 64'(bus.Load_Err), 64'd1);
    chk("bad_busy", 64'(bus.Load_Busy), 64'd0);
    chk("bad_hold", 64'(bus.Core_Hold), 64'(exp_hold));
    chk("bad_done", 64'(bus.Load_Done), 64'(exp_done));
    tick;
    chk("bad_err_pulse", 64'(bus.Load_Err), 64'd0);
    chk("bad_no_wr", 64'(bus.Mem_Wr_En), 64'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.Load_Start = 1'b0; bus.Load_Len = '0; bus.Load_Abort = 1'b0;
    bus.Rx_Data = '0; bus.Rx_Valid = 1'b0;
    #12;
    chk("rst_hold", 64'(bus.Core_Hold), 64'd1);
    chk("rst_addr", bus.Mem_Wr_Addr, 64'd0);
    chk("rst_outs", 64'({bus.Rx_Ready, bus.Mem_Wr_En, bus.Word_Valid, bus.Load_Busy,
                         bus.Load_Done, bus.Load_Err, bus.Checksum, bus.Instr_Word}), 64'd0);
    tick; reset = 1'b1;

    // Rx traffic while idle is ignored
    bus.Rx_Valid = 1'b1; bus.Rx_Data = 8'h5A;
    repeat (3) begin
      tick;
      chk("idle_rx_wr", 64'(bus.Mem_Wr_En), 64'd0);
      chk("idle_rx_cks", 64'(bus.Checksum), 64'd0);
    end
    bus.Rx_Valid = 1'b0;

    bad_start(6, 1'b1, 1'b0);
    bad_start(0, 1'b1, 1'b0);
    bad_start(136, 1'b1, 1'b0);

    // Fixed program image
    img[0] = 8'h93; img[1] = 8'h02; img[2] = 8'h90; img[3] = 8'h01;
    img[4] = 8'h23; img[5] = 8'h32; img[6] = 8'h50; img[7] = 8'h00;
    wv_cnt = 0;
    do_load(8, 1, -1);
    chk("t1_checksum_const", 64'(bus.Checksum), 64'hCB);
    chk("t1_words", 64'(wv_cnt), 64'd2);
    chk("t1_last_word", 64'(bus.Instr_Word), 64'h0050_3223);

    rand_img; wr_cnt = 0;
    do_load(4, 2, -1);
    chk("t3_wr_cnt", 64'(wr_cnt), 64'd4);

    rand_img; wr_cnt = 0;
    do_load(8, 1, 2);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd2);

    // Async reset between clock edges in the middle of a load
    rand_img;
    bus.Load_Start = 1'b1; bus.Load_Len = 16'd8;
    tick;
    bus.Load_Start = 1'b0; bus.Rx_Valid = 1'b1; bus.Rx_Data = img[0];
    tick;
    bus.Rx_Data = img[1];
    tick;
    bus.Rx_Valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_hold", 64'(bus.Core_Hold), 64'd1);
    chk("mid_rst_addr", bus.Mem_Wr_Addr, 64'd0);
    chk("mid_rst_outs", 64'({bus.Rx_Ready, bus.Mem_Wr_En, bus.Word_Valid, bus.Load_Busy,
                             bus.Load_Done, bus.Load_Err, bus.Checksum, bus.Mem_Wr_Data}), 64'd0);
    reset = 1'b1;
    tick;
    do_load(4, 1, -1);

    // Full-size image, then reload from DONE
    rand_img; wv_cnt = 0;
    do_load(132, 1, -1);
    chk("t6_words", 64'(wv_cnt), 64'd33);
    chk("t6_last_addr", last_addr, 64'd131);
    bad_start(133, 1'b0, 1'b1);
    bad_start(10, 1'b0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      rand_img;
      do_load(4 * int'($urandom_range(1, 33)), 0, -1);
    end
    rand_img;
    do_load(4 * int'($urandom_range(2, 33)), 0, int'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
